dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller between the CPU core's load/store port and a word-wide single-port synchronous RAM. It translates byte addresses, performs byte/halfword read-modify-write for SB/SH, and right-justifies loaded bytes and halfwords so the core's sign/zero extension acts on bits [7:0]/[15:0]. It stalls the core for every access needing a RAM read.

## Interface
- ADDR_W, 11, RAM word-address width
- BASE_ADDR, 32'h1001_0000, byte address mapped to RAM word 0
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_r  in  1  load request (core DMem_r)
- req_w  in  1  store request (core DMem_w)
- req_sel  in  2  access size: 2'b11 word, 2'b01 half, 2'b00 byte; 2'b10 is decoded as byte
- req_addr  in  32  byte address (core ALU result)
- req_wdata  in  32  store data; byte uses [7:0], half uses [15:0]
- rdata  out  32  load result, lane shifted to bit 0, upper bits zero
- stall  out  1  core must hold the PC and suppress register-file write while high
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable (whole word)
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write word
- ram_rdata  in  32  RAM read word, valid one cycle after a read is issued
- misalign  out  1  misaligned-access flag (present only with DMEM_ALIGN_CHECK_EN)

## Operation
- Word address: ((req_addr − BASE_ADDR) >> 2), truncated to ADDR_W bits. Byte offset: req_addr[1:0]. Byte lanes are little-endian (offset 0 = bits [7:0]).
- FSM states: IDLE, RD_WAIT, RMW_WR.
- IDLE, req_r: issue a RAM read. Capture word address, offset and size. Assert stall. Go to RD_WAIT.
- IDLE, req_w with size word: issue a RAM write with req_wdata. No stall. Stay in IDLE.
- IDLE, req_w with size byte or half: issue a RAM read. Capture address, offset, size and write data. Assert stall. Go to RMW_WR.
- RD_WAIT: rdata = ram_rdata shifted right by 8×offset (half uses 16×offset[1]), masked to size. stall=0. Go to IDLE.
- RMW_WR: ram_wdata = ram_rdata with the captured byte/half lanes replaced. Assert ram_en and ram_we. stall=0. Go to IDLE.
- req_r and req_w both high: treated as a load; the store is ignored.
- No request in IDLE: ram_en=0, stall=0, rdata=0.
- The core holds its request stable while stall=1. The controller uses only captured values after IDLE.

## Timing
- Reset: state=IDLE, all captured registers 0, and while reset is high stall=0, ram_en=0, ram_we=0, rdata=0.
- Load: 2 cycles. The issue cycle has stall=1; rdata is valid in the following cycle with stall=0, and the core writes back at that cycle's edge.
- SW: 1 cycle, zero stall. The write commits at the issue edge.
- SB/SH: 2 cycles, one stall cycle. The merged word commits at the end of the RMW_WR cycle.
- Back-to-back accesses: after RD_WAIT or RMW_WR the FSM is in IDLE when the next instruction's request appears. No bubble is added.
- Reset asserted mid-RMW: the FSM returns to IDLE immediately, no RAM write occurs, and the pending store is dropped.
- Addresses outside the RAM wrap modulo 2^ADDR_W words. No error is raised.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - misalign is a combinational output in IDLE, asserted for a half access with addr[0]=1 or a word access with addr[1:0]≠0.
  - The flagged access is suppressed: no RAM enable, stall=0, rdata=0.
- DMEM_ALIGN_CHECK_EN undefined:
  - The misalign port is absent.
  - Low address bits are ignored: a half access uses offset[1] only, and a word access ignores offset entirely.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, RD_WAIT, RMW_WR);
  - the size encodings SEL_BYTE=2'b00, SEL_HALF=2'b01, SEL_WORD=2'b11.
- Sub-module dmem_lane is purely combinational:
  - extract: word, offset, size → right-justified data;
  - merge: old word, new data, offset, size → written word.

## Test plan
- Reset, then SW 32'hDEADBEEF at 32'h1001_0004 → one cycle with ram_we=1 and ram_addr=1, stall=0 throughout.
- Continue with LB-size load at 32'h1001_0006 → stall=1 for one cycle, then rdata=32'h0000_00AD.
- SB 32'h0000_0055 at 32'h1001_0005 → read cycle with stall=1, then a write of 32'hDEAD55EF; a word load at 32'h1001_0004 then returns 32'hDEAD55EF.
- SH 32'h1234 at 32'h1001_0006, then a half load there → rdata=32'h0000_1234; a word load at 32'h1001_0004 returns 32'h123455EF.
- Reset pulse during the RMW_WR cycle of an SB → no RAM write, and the word load afterwards still returns the prior value.
- With DMEM_ALIGN_CHECK_EN, SH at 32'h1001_0001 → misalign=1, ram_en=0, stall=0, and memory is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: FSM states and access-size codes.
// Pure declarations; no timing or backpressure of its own.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR} state_t;

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b11;
endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: right-justify a loaded lane and merge a store lane into an old word.
// Purely combinational, zero latency; no flow control.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_new,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_sel,
    output logic [31:0] o_data,
    output logic [31:0] o_merged
);
    logic [31:0] w_bsh;
    logic [31:0] w_hsh;

    assign w_bsh = i_word >> {i_off, 3'b000};
    assign w_hsh = i_word >> {i_off[1], 4'b0000};

    always_comb begin
        o_data   = '0;
        o_merged = i_word;
        case (i_sel)
            SEL_WORD: begin
                o_data   = i_word;
                o_merged = i_new;
            end
            // Halves ignore offset[0]; lane is picked by offset[1] alone.
            SEL_HALF: begin
                o_data = {16'h0000, w_hsh[15:0]};
                o_merged[{i_off[1], 4'b0000} +: 16] = i_new[15:0];
            end
            default: begin
                o_data = {24'h000000, w_bsh[7:0]};
                o_merged[{i_off, 3'b000} +: 8] = i_new[7:0];
            end
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Load/store port to single-port sync RAM; loads and SB/SH take 2 cycles (1 stall), SW takes 1.
// Stalls the core while a RAM read is outstanding; DMEM_ALIGN_CHECK_EN adds the misalign flag.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_r,
    input  logic              req_w,
    input  logic [1:0]        req_sel,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_off;
    logic [1:0]        r_sel;
    logic [31:0]       r_wdata;

    logic [ADDR_W-1:0] w_waddr;
    logic              w_bad;
    logic              w_go;
    logic [31:0]       w_ext;
    logic [31:0]       w_merged;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE_ADDR;
        return d[ADDR_W+1:2];
    endfunction

    assign w_waddr = word_addr(req_addr);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_bad    = ((req_sel == SEL_HALF) && req_addr[0]) ||
                      ((req_sel == SEL_WORD) && (req_addr[1:0] != 2'b00));
    assign misalign = !reset && (r_state == IDLE) && (req_r || req_w) && w_bad;
`else
    assign w_bad = 1'b0;
`endif

    assign w_go = (req_r || req_w) && !w_bad;

    dmem_lane u_lane (
        .i_word  (ram_rdata),
        .i_new   (r_wdata),
        .i_off   (r_off),
        .i_sel   (r_sel),
        .o_data  (w_ext),
        .o_merged(w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_off   <= '0;
            r_sel   <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_addr  <= w_waddr;
                        r_off   <= req_addr[1:0];
                        r_sel   <= req_sel;
                        r_wdata <= req_wdata;
                        // A simultaneous load and store is taken as a load.
                        if (req_r)
                            r_state <= RD_WAIT;
                        else if (req_sel != SEL_WORD)
                            r_state <= RMW_WR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata     = '0;
        stall     = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = w_waddr;
        ram_wdata = req_wdata;
        case (r_state)
            IDLE: begin
                if (!reset && w_go) begin
                    ram_en = 1'b1;
                    if (!req_r && req_sel == SEL_WORD)
                        ram_we = 1'b1;
                    else
                        stall = 1'b1;
                end
            end
            RD_WAIT: rdata = w_ext;
            RMW_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_addr;
                ram_wdata = w_merged;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural single-port sync RAM behind it.
// Cycle vectors hold core request and expected port values; corner sequences follow.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_r, req_w;
    logic [1:0]  req_sel;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rdata;
    logic        stall, ram_en, ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(11), .BASE_ADDR(32'h1001_0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_r    (req_r),
        .req_w    (req_w),
        .req_sel  (req_sel),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rdata    (rdata),
        .stall    (stall),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .misalign (misalign)
`endif
    );

    logic [31:0] mem [0:2047];
    initial begin
        for (int k = 0; k < 2048; k++) mem[k] = 32'h0;
        ram_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        r, w;
        logic [1:0]  sel;
        logic [31:0] addr, wdata;
        logic        e_stall, e_en, e_we;
        logic [10:0] e_addr;
        logic [31:0] e_wdata, e_rdata;
    } vec_t;

    localparam int NV = 30;
    vec_t tv [NV];

    function automatic vec_t mk(input logic r, input logic w, input logic [1:0] sel,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic es, input logic een, input logic ewe,
                                input logic [10:0] ea, input logic [31:0] ewd,
                                input logic [31:0] erd);
        vec_t v;
        v.r = r; v.w = w; v.sel = sel; v.addr = addr; v.wdata = wdata;
        v.e_stall = es; v.e_en = een; v.e_we = ewe; v.e_addr = ea;
        v.e_wdata = ewd; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_r = r; req_w = w; req_sel = sel; req_addr = addr; req_wdata = wdata;
    endtask

    initial begin
        // Each two-cycle access appears twice: issue cycle, then the held request.
        tv[0]  = mk(0,0,2'b00,32'h1001_0000,32'h0,        0,0,0,11'h000,32'h0,        32'h0);
        tv[1]  = mk(0,1,2'b11,32'h1001_0004,32'hDEADBEEF, 0,1,1,11'h001,32'hDEADBEEF, 32'h0);
        tv[2]  = mk(1,0,2'b00,32'h1001_0006,32'h0,        1,1,0,11'h001,32'h0,        32'h0);
        tv[3]  = mk(1,0,2'b00,32'h1001_0006,32'h0,        0,0,0,11'h000,32'h0,        32'h0000_00AD);
        tv[4]  = mk(0,1,2'b00,32'h1001_0005,32'h55,       1,1,0,11'h001,32'h0,        32'h0);
        tv[5]  = mk(0,1,2'b00,32'h1001_0005,32'h55,       0,1,1,11'h001,32'hDEAD55EF, 32'h0);
        tv[6]  = mk(1,0,2'b11,32'h1001_0004,32'h0,        1,1,0,11'h001,32'h0,        32'h0);
        tv[7]  = mk(1,0,2'b11,32'h1001_0004,32'h0,        0,0,0,11'h000,32'h0,        32'hDEAD55EF);
        tv[8]  = mk(0,1,2'b01,32'h1001_0006,32'h1234,     1,1,0,11'h001,32'h0,        32'h0);
        tv[9]  = mk(0,1,2'b01,32'h1001_0006,32'h1234,     0,1,1,11'h001,32'h123455EF, 32'h0);
        tv[10] = mk(1,0,2'b01,32'h1001_0006,32'h0,        1,1,0,11'h001,32'h0,        32'h0);
        tv[11] = mk(1,0,2'b01,32'h1001_0006,32'h0,        0,0,0,11'h000,32'h0,        32'h0000_1234);
        tv[12] = mk(1,0,2'b11,32'h1001_0004,32'h0,        1,1,0,11'h001,32'h0,        32'h0);
        tv[13] = mk(1,0,2'b11,32'h1001_0004,32'h0,        0,0,0,11'h000,32'h0,        32'h123455EF);
        tv[14] = mk(1,0,2'b10,32'h1001_0007,32'h0,        1,1,0,11'h001,32'h0,        32'h0);
        tv[15] = mk(1,0,2'b10,32'h1001_0007,32'h0,        0,0,0,11'h000,32'h0,        32'h0000_0012);
        tv[16] = mk(0,1,2'b11,32'h1000_FFFC,32'hA5A50001, 0,1,1,11'h7FF,32'hA5A50001, 32'h0);
        tv[17] = mk(1,0,2'b11,32'h1000_FFFC,32'h0,        1,1,0,11'h7FF,32'h0,        32'h0);
        tv[18] = mk(1,0,2'b11,32'h1000_FFFC,32'h0,        0,0,0,11'h000,32'h0,        32'hA5A50001);
        tv[19] = mk(0,1,2'b11,32'h1001_2008,32'hCAFEF00D, 0,1,1,11'h002,32'hCAFEF00D, 32'h0);
        tv[20] = mk(1,0,2'b11,32'h1001_0008,32'h0,        1,1,0,11'h002,32'h0,        32'h0);
        tv[21] = mk(1,0,2'b11,32'h1001_0008,32'h0,        0,0,0,11'h000,32'h0,        32'hCAFEF00D);
        tv[22] = mk(1,0,2'b01,32'h1001_000A,32'h0,        1,1,0,11'h002,32'h0,        32'h0);
        tv[23] = mk(1,0,2'b01,32'h1001_000A,32'h0,        0,0,0,11'h000,32'h0,        32'h0000_CAFE);
        tv[24] = mk(1,0,2'b00,32'h1001_0009,32'h0,        1,1,0,11'h002,32'h0,        32'h0);
        tv[25] = mk(1,0,2'b00,32'h1001_0009,32'h0,        0,0,0,11'h000,32'h0,        32'h0000_00F0);
        tv[26] = mk(0,1,2'b00,32'h1001_0008,32'hFFFFFF99, 1,1,0,11'h002,32'h0,        32'h0);
        tv[27] = mk(0,1,2'b00,32'h1001_0008,32'hFFFFFF99, 0,1,1,11'h002,32'hCAFEF099, 32'h0);
        tv[28] = mk(1,1,2'b11,32'h1001_0004,32'h0,        1,1,0,11'h001,32'h0,        32'h0);
        tv[29] = mk(1,1,2'b11,32'h1001_0004,32'h0,        0,0,0,11'h000,32'h0,        32'h123455EF);

        reset = 1'b1;
        drive(1, 0, 2'b11, 32'h1001_0004, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("reset stall",  {31'h0, stall},  32'h0);
        chk("reset ram_en", {31'h0, ram_en}, 32'h0);
        chk("reset ram_we", {31'h0, ram_we}, 32'h0);
        chk("reset rdata",  rdata,           32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].r, tv[i].w, tv[i].sel, tv[i].addr, tv[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d stall", i),  {31'h0, stall},  {31'h0, tv[i].e_stall});
            chk($sformatf("v%0d ram_en", i), {31'h0, ram_en}, {31'h0, tv[i].e_en});
            chk($sformatf("v%0d ram_we", i), {31'h0, ram_we}, {31'h0, tv[i].e_we});
            chk($sformatf("v%0d rdata", i),  rdata,           tv[i].e_rdata);
            if (tv[i].e_en)
                chk($sformatf("v%0d ram_addr", i), {21'h0, ram_addr}, {21'h0, tv[i].e_addr});
            if (tv[i].e_we)
                chk($sformatf("v%0d ram_wdata", i), ram_wdata, tv[i].e_wdata);
            @(posedge clk); #1;
        end

        // Reset pulse during the merge cycle of a byte store drops the write.
        drive(0, 1, 2'b00, 32'h1001_0004, 32'h77);
        @(negedge clk);
        chk("rmw issue stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rmw reset ram_we", {31'h0, ram_we}, 32'h0);
        chk("rmw reset ram_en", {31'h0, ram_en}, 32'h0);
        chk("rmw reset stall",  {31'h0, stall},  32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 0, 2'b00, 32'h1001_0000, 32'h0);
        @(posedge clk); #1;
        drive(1, 0, 2'b11, 32'h1001_0004, 32'h0);
        @(negedge clk);
        chk("post reset lw stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post reset lw rdata", rdata, 32'h123455EF);
        @(posedge clk); #1;

`ifdef DMEM_ALIGN_CHECK_EN
        drive(0, 1, 2'b01, 32'h1001_0001, 32'h1234);
        @(negedge clk);
        chk("mis sh flag",   {31'h0, misalign}, 32'h1);
        chk("mis sh ram_en", {31'h0, ram_en},   32'h0);
        chk("mis sh stall",  {31'h0, stall},    32'h0);
        chk("mis sh rdata",  rdata,             32'h0);
        @(posedge clk); #1;
        drive(1, 0, 2'b11, 32'h1001_0000, 32'h0);
        @(negedge clk);
        chk("mis lw flag",  {31'h0, misalign}, 32'h0);
        chk("mis lw stall", {31'h0, stall},    32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis lw rdata", rdata, 32'h0);
        @(posedge clk); #1;
`else
        drive(1, 0, 2'b01, 32'h1001_0005, 32'h0);
        @(negedge clk);
        chk("odd lh stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("odd lh rdata", rdata, 32'h0000_55EF);
        @(posedge clk); #1;
        drive(1, 0, 2'b11, 32'h1001_0007, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("odd lw rdata", rdata, 32'h123455EF);
        @(posedge clk); #1;
`endif

        drive(0, 0, 2'b00, 32'h1001_0000, 32'h0);
        @(negedge clk);
        chk("idle stall", {31'h0, stall}, 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
